// File: rtl/vdma_pkg.sv
// rtl/vdma_pkg.sv - shared types, limits and address helper for the VDMA frame ring
package vdma_pkg;

  localparam int MAX_BUF = 16;
  localparam int MAX_RD  = 4;

  // Wide enough to index the largest supported ring.
  typedef logic [$clog2(MAX_BUF)-1:0] point_t;

  // Pointer width for a ring of n buffers; never narrower than one bit.
  function automatic int point_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Reader ports are capped so the busy-mask fan-in stays bounded.
  function automatic bit rd_count_ok(input int n);
    return (n >= 1) && (n <= MAX_RD);
  endfunction

  // Byte address of a buffer; callers truncate to their address width.
  function automatic logic [63:0] point_addr(input logic [63:0] base,
                                             input logic [63:0] stride,
                                             input point_t      p);
    return base + stride * {{(64-$bits(point_t)){1'b0}}, p};
  endfunction

endpackage

// File: rtl/vdma_frame_ring_if.sv
// rtl/vdma_frame_ring_if.sv - vsync inputs and pointer/address outputs of the frame ring
interface vdma_frame_ring_if
  import vdma_pkg::*;
#(
  parameter int NUM_BUF = 3,
  parameter int NUM_RD  = 2,
  parameter int ASIZE   = 29
);
  localparam int PSIZE = point_width(NUM_BUF);

  logic                    wr_enable;
  logic                    wr_vs;
  logic [NUM_RD-1:0]       rd_vs;
  logic [PSIZE-1:0]        wr_point;
  logic [ASIZE-1:0]        wr_baseaddr;
  logic [PSIZE-1:0]        latest_point;
  logic                    latest_valid;
  logic [NUM_RD*PSIZE-1:0] rd_point;
  logic [NUM_RD*ASIZE-1:0] rd_baseaddr;
  logic [NUM_RD-1:0]       rd_valid;
  logic                    wr_drop;

  modport master (
    output wr_enable, wr_vs, rd_vs,
    input  wr_point, wr_baseaddr, latest_point, latest_valid,
           rd_point, rd_baseaddr, rd_valid, wr_drop
  );

  modport slave (
    input  wr_enable, wr_vs, rd_vs,
    output wr_point, wr_baseaddr, latest_point, latest_valid,
           rd_point, rd_baseaddr, rd_valid, wr_drop
  );

endinterface

// File: rtl/vdma_free_pick.sv
// rtl/vdma_free_pick.sv - rotating find-first-free over the buffer busy mask
module vdma_free_pick #(
  parameter int NUM_BUF = 3,
  parameter int PSIZE   = 2
) (
  input  logic [NUM_BUF-1:0] busy,
  input  logic [PSIZE-1:0]   start,
  output logic [PSIZE-1:0]   pick,
  output logic               found
);

  // Walk the ring from start, wrapping at NUM_BUF, and keep the first idle slot.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NUM_BUF; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_BUF) idx = idx - NUM_BUF;
      if (!found && !busy[idx]) begin
        found = 1'b1;
        pick  = PSIZE'(idx);
      end
    end
  end

endmodule

// File: rtl/vdma_frame_ring.sv
// rtl/vdma_frame_ring.sv - frame-buffer pointer manager (optional drop counter: VDMA_FRAME_DROP_CNT_EN)
module vdma_frame_ring
  import vdma_pkg::*;
#(
  parameter int          NUM_BUF      = 3,
  parameter int          NUM_RD       = 2,
  parameter int          ASIZE        = 29,
  parameter logic [63:0] BASE_ADDR    = 64'd0,
  parameter logic [31:0] FRAME_STRIDE = 32'h0080_0000
) (
  input  logic             clock,
  input  logic             rst,
  vdma_frame_ring_if.slave bus
`ifdef VDMA_FRAME_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int PSIZE = point_width(NUM_BUF);
  localparam bit RD_OK = rd_count_ok(NUM_RD);

  typedef logic [PSIZE-1:0] idx_t;

  function automatic logic [ASIZE-1:0] addr_of(input idx_t p);
    return ASIZE'(point_addr(BASE_ADDR, 64'(FRAME_STRIDE), point_t'(p)));
  endfunction

  // vsync levels are flopped once, then compared with a second copy. Both
  // reset high so a vsync already high at reset release is not an edge.
  logic              wr_vs_r, wr_vs_q, en_r;
  logic [NUM_RD-1:0] rd_vs_r, rd_vs_q;
  logic              wr_ev;
  logic [NUM_RD-1:0] rd_rise;

  idx_t              wr_pt, wr_pt_n, lat_pt, lat_pt_n;
  logic              lat_vld, lat_vld_n;
  idx_t              rd_pt   [NUM_RD];
  idx_t              rd_pt_n [NUM_RD];
  logic [NUM_RD-1:0] rd_vld, rd_vld_n;
  logic [ASIZE-1:0]  wr_addr;
  logic [ASIZE-1:0]  rd_addr [NUM_RD];
  logic              drop, drop_n;

  logic [NUM_BUF-1:0] busy;
  idx_t               start, pick;
  logic               found;

  assign wr_ev   = wr_vs_r & ~wr_vs_q & en_r & RD_OK;
  assign rd_rise = rd_vs_r & ~rd_vs_q;

  // Reader locks sample the pre-commit latest frame; the busy mask then
  // includes those fresh locks so the writer never lands on them.
  always_comb begin
    rd_pt_n  = rd_pt;
    rd_vld_n = rd_vld;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_rise[i] && lat_vld) begin
        rd_pt_n[i]  = lat_pt;
        rd_vld_n[i] = 1'b1;
      end
    end
    busy        = '0;
    busy[wr_pt] = 1'b1;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_vld_n[i]) busy[rd_pt_n[i]] = 1'b1;
    end
    start = (wr_pt == idx_t'(NUM_BUF - 1)) ? '0 : wr_pt + 1'b1;
  end

  vdma_free_pick #(
    .NUM_BUF (NUM_BUF),
    .PSIZE   (PSIZE)
  ) u_pick (
    .busy  (busy),
    .start (start),
    .pick  (pick),
    .found (found)
  );

  // Writer frame boundary: commit and move on, or drop the frame when every
  // buffer is taken.
  always_comb begin
    wr_pt_n   = wr_pt;
    lat_pt_n  = lat_pt;
    lat_vld_n = lat_vld;
    drop_n    = 1'b0;
    if (wr_ev) begin
      if (found) begin
        lat_pt_n  = wr_pt;
        lat_vld_n = 1'b1;
        wr_pt_n   = pick;
      end else begin
        drop_n = 1'b1;
      end
    end
  end

  // State registers; base addresses are loaded from the same next-point values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_vs_r <= 1'b1;
      wr_vs_q <= 1'b1;
      en_r    <= 1'b0;
      rd_vs_r <= '1;
      rd_vs_q <= '1;
      wr_pt   <= '0;
      lat_pt  <= '0;
      lat_vld <= 1'b0;
      rd_vld  <= '0;
      drop    <= 1'b0;
      wr_addr <= addr_of('0);
      for (int i = 0; i < NUM_RD; i++) begin
        rd_pt[i]   <= '0;
        rd_addr[i] <= addr_of('0);
      end
    end else begin
      wr_vs_r <= bus.wr_vs;
      wr_vs_q <= wr_vs_r;
      en_r    <= bus.wr_enable;
      rd_vs_r <= bus.rd_vs;
      rd_vs_q <= rd_vs_r;
      wr_pt   <= wr_pt_n;
      lat_pt  <= lat_pt_n;
      lat_vld <= lat_vld_n;
      rd_vld  <= rd_vld_n;
      drop    <= drop_n;
      wr_addr <= addr_of(wr_pt_n);
      for (int i = 0; i < NUM_RD; i++) begin
        rd_pt[i]   <= rd_pt_n[i];
        rd_addr[i] <= addr_of(rd_pt_n[i]);
      end
    end
  end

`ifdef VDMA_FRAME_DROP_CNT_EN
  // Saturating drop counter, updated together with the wr_drop pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_n && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  assign bus.wr_point     = wr_pt;
  assign bus.wr_baseaddr  = wr_addr;
  assign bus.latest_point = lat_pt;
  assign bus.latest_valid = lat_vld;
  assign bus.rd_valid     = rd_vld;
  assign bus.wr_drop      = drop;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_out
    assign bus.rd_point[g*PSIZE +: PSIZE]    = rd_pt[g];
    assign bus.rd_baseaddr[g*ASIZE +: ASIZE] = rd_addr[g];
  end

endmodule

// File: tb/tb_vdma_frame_ring.sv
// tb/tb_vdma_frame_ring.sv - table-driven scoreboard bench for vdma_frame_ring
module tb_vdma_frame_ring;

  localparam int NUM_BUF = 3;
  localparam int NUM_RD  = 2;
  localparam int ASIZE   = 29;
  localparam int PSIZE   = 2;
  localparam logic [31:0] STRIDE = 32'h0080_0000;

  typedef struct {
    bit       en;
    bit       wv;
    bit [1:0] rv;
    int       wr;
    int       lat;
    bit       lv;
    int       rd0;
    int       rd1;
    bit [1:0] rvld;
    bit       drop;
    int       dc;
  } vec_t;

  logic clock;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];
  vec_t seq_a[$];
  vec_t sb[$];

  vdma_frame_ring_if #(.NUM_BUF(NUM_BUF), .NUM_RD(NUM_RD), .ASIZE(ASIZE)) bus ();

`ifdef VDMA_FRAME_DROP_CNT_EN
  logic [15:0] drop_cnt;
  vdma_frame_ring #(.NUM_BUF(NUM_BUF), .NUM_RD(NUM_RD), .ASIZE(ASIZE)) dut (
    .clock    (clock),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );
`else
  vdma_frame_ring #(.NUM_BUF(NUM_BUF), .NUM_RD(NUM_RD), .ASIZE(ASIZE)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(bit en, bit wv, bit [1:0] rv, int wr, int lat, bit lv,
                              int rd0, int rd1, bit [1:0] rvld, bit drop, int dc);
    vec_t v;
    v.en = en; v.wv = wv; v.rv = rv; v.wr = wr; v.lat = lat; v.lv = lv;
    v.rd0 = rd0; v.rd1 = rd1; v.rvld = rvld; v.drop = drop; v.dc = dc;
    return v;
  endfunction

  function automatic logic [ASIZE-1:0] exp_addr(int p);
    logic [63:0] a;
    a = 64'(p) * 64'(STRIDE);
    return a[ASIZE-1:0];
  endfunction

  task automatic cmp(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check(input vec_t e);
    cmp("wr_point",      longint'(bus.wr_point), longint'(e.wr));
    cmp("wr_baseaddr",   longint'(bus.wr_baseaddr), longint'(exp_addr(e.wr)));
    cmp("latest_point",  longint'(bus.latest_point), longint'(e.lat));
    cmp("latest_valid",  longint'(bus.latest_valid), longint'(e.lv));
    cmp("rd_point0",     longint'(bus.rd_point[0 +: PSIZE]), longint'(e.rd0));
    cmp("rd_point1",     longint'(bus.rd_point[PSIZE +: PSIZE]), longint'(e.rd1));
    cmp("rd_baseaddr0",  longint'(bus.rd_baseaddr[0 +: ASIZE]), longint'(exp_addr(e.rd0)));
    cmp("rd_baseaddr1",  longint'(bus.rd_baseaddr[ASIZE +: ASIZE]), longint'(exp_addr(e.rd1)));
    cmp("rd_valid",      longint'(bus.rd_valid), longint'(e.rvld));
    cmp("wr_drop",       longint'(bus.wr_drop), longint'(e.drop));
`ifdef VDMA_FRAME_DROP_CNT_EN
    cmp("drop_cnt",      longint'(drop_cnt), longint'(e.dc));
`endif
  endtask

  // One vector per cycle; its effect is visible two falling edges later.
  task automatic step(input vec_t v);
    @(negedge clock);
    if (sb.size() == 2) check(sb.pop_front());
    bus.wr_enable = v.en;
    bus.wr_vs     = v.wv;
    bus.rd_vs     = v.rv;
    sb.push_back(v);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      @(negedge clock);
      check(sb.pop_front());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // en, wv, rv  ->  wr, lat, lv, rd0, rd1, rvld, drop, dc
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 1, 0, 0, 2'b01, 0, 0));
    tbl.push_back(mk(1, 0, 2'b00, 1, 0, 1, 0, 0, 2'b01, 0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 2, 1, 1, 0, 0, 2'b01, 0, 0));
    tbl.push_back(mk(1, 0, 2'b10, 2, 1, 1, 0, 1, 2'b11, 0, 0));
    tbl.push_back(mk(1, 1, 2'b00, 2, 1, 1, 0, 1, 2'b11, 1, 1));
    tbl.push_back(mk(1, 0, 2'b00, 2, 1, 1, 0, 1, 2'b11, 0, 1));
    tbl.push_back(mk(0, 1, 2'b01, 2, 1, 1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 2'b00, 2, 1, 1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 1, 2'b00, 0, 2, 1, 1, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 2'b01, 0, 2, 1, 2, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 0, 2'b00, 0, 2, 1, 2, 1, 2'b11, 0, 1));
    tbl.push_back(mk(1, 1, 2'b00, 0, 2, 1, 2, 1, 2'b11, 1, 2));
    tbl.push_back(mk(1, 0, 2'b00, 0, 2, 1, 2, 1, 2'b11, 0, 2));

    // After a mid-run reset with vsyncs held high: no event, then a
    // simultaneous writer/reader edge, a skip over a locked buffer, and a drop.
    seq_a.push_back(mk(1, 1, 2'b11, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    seq_a.push_back(mk(1, 1, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 0));
    seq_a.push_back(mk(1, 1, 2'b01, 2, 1, 1, 0, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b00, 2, 1, 1, 0, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 1, 2'b00, 1, 2, 1, 0, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b01, 1, 2, 1, 2, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b00, 1, 2, 1, 2, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 1, 2'b00, 0, 1, 1, 2, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b00, 0, 1, 1, 2, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 1, 2'b00, 1, 0, 1, 2, 0, 2'b01, 0, 0));
    seq_a.push_back(mk(1, 0, 2'b10, 1, 0, 1, 2, 0, 2'b11, 0, 0));
    seq_a.push_back(mk(1, 1, 2'b00, 1, 0, 1, 2, 0, 2'b11, 1, 1));
    seq_a.push_back(mk(1, 0, 2'b00, 1, 0, 1, 2, 0, 2'b11, 0, 1));

    rst           = 1'b1;
    bus.wr_enable = 1'b0;
    bus.wr_vs     = 1'b0;
    bus.rd_vs     = 2'b00;
    repeat (3) @(negedge clock);
    check(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    drain();

    // Asynchronous reset between clock edges while readers hold frames.
    @(negedge clock);
    #2;
    rst       = 1'b1;
    bus.wr_vs = 1'b1;
    bus.rd_vs = 2'b11;
    #1;
    check(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    repeat (2) @(negedge clock);
    rst = 1'b0;

    for (int i = 0; i < seq_a.size(); i++) step(seq_a[i]);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
